// File: rtl/sfm_acc_ctrl.sv
// Softmax accumulator controller: sequences row accumulation, final reduction and
// the Newton-Raphson reciprocal of the denominator. All outputs decode registered state.
module sfm_acc_ctrl #(
  parameter int unsigned N_NEWTON_ITERS = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clear_i,
  input  logic       start_i,
  input  logic       acc_finished_i,
  input  logic       acc_only_i,
  input  logic       addend_empty_i,
  input  logic       last_op_in_flight_i,
  input  logic       inv_appr_valid_i,
  input  logic       fma_o_valid_i,
  output logic       busy_o,
  output logic       disable_ready_o,
  output logic       reducing_o,
  output logic       inverting_o,
  output logic       inv_enable_o,
  output logic       fma_inv_valid_o,
  output logic       new_inv_iter_o,
  output logic       first_inv_iter_o,
  output logic       acc_done_o,
  output logic       inv_done_o,
  output logic [2:0] inv_iter_o
);

  localparam int unsigned STEP_W = 4;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(2 * N_NEWTON_ITERS - 1);

  typedef enum logic [2:0] {
    IDLE, ACC, REDUCE, INV_START, FMA_ISSUE, FMA_WAIT, DONE
  } state_e;

  state_e              state_q, state_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic                acc_only_q, acc_only_d;
  logic                inv_first_q, inv_first_d;

  // State and counter registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      step_q      <= '0;
      acc_only_q  <= 1'b0;
      inv_first_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      acc_only_q  <= acc_only_d;
      inv_first_q <= inv_first_d;
    end
  end

  // Next-state logic; inv_first marks the single INV_START cycle that fires inv_enable_o
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    acc_only_d  = acc_only_q;
    inv_first_d = 1'b0;
    if (clear_i) begin
      state_d    = IDLE;
      step_d     = '0;
      acc_only_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (start_i) state_d = ACC;
        ACC: begin
          if (acc_finished_i) begin
            state_d    = REDUCE;
            acc_only_d = acc_only_i;
          end
        end
        REDUCE: begin
          if (addend_empty_i && !last_op_in_flight_i) begin
            state_d     = acc_only_q ? DONE : INV_START;
            inv_first_d = !acc_only_q;
          end
        end
        INV_START: begin
          if (inv_appr_valid_i) begin
            state_d = FMA_ISSUE;
            step_d  = '0;
          end
        end
        FMA_ISSUE: state_d = FMA_WAIT;
        FMA_WAIT: begin
          if (fma_o_valid_i) begin
            if (step_q == LAST_STEP) begin
              state_d = DONE;
            end else begin
              state_d = FMA_ISSUE;
              step_d  = step_q + STEP_W'(1);
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Moore output decode
  always_comb begin
    busy_o           = 1'b0;
    disable_ready_o  = 1'b0;
    reducing_o       = 1'b0;
    inverting_o      = 1'b0;
    inv_enable_o     = 1'b0;
    fma_inv_valid_o  = 1'b0;
    new_inv_iter_o   = 1'b0;
    first_inv_iter_o = 1'b0;
    acc_done_o       = 1'b0;
    inv_done_o       = 1'b0;
    inv_iter_o       = step_q[3:1];
    unique case (state_q)
      IDLE: ;
      ACC: busy_o = 1'b1;
      REDUCE: begin
        busy_o          = 1'b1;
        disable_ready_o = 1'b1;
        reducing_o      = 1'b1;
      end
      INV_START: begin
        busy_o          = 1'b1;
        disable_ready_o = 1'b1;
        inverting_o     = 1'b1;
        inv_enable_o    = inv_first_q;
      end
      FMA_ISSUE: begin
        busy_o           = 1'b1;
        disable_ready_o  = 1'b1;
        inverting_o      = 1'b1;
        fma_inv_valid_o  = 1'b1;
        new_inv_iter_o   = !step_q[0];
        first_inv_iter_o = (step_q < STEP_W'(2));
      end
      FMA_WAIT: begin
        busy_o           = 1'b1;
        disable_ready_o  = 1'b1;
        inverting_o      = 1'b1;
        first_inv_iter_o = (step_q < STEP_W'(2));
      end
      DONE: begin
        busy_o          = 1'b1;
        disable_ready_o = 1'b1;
        acc_done_o      = 1'b1;
        inv_done_o      = !acc_only_q;
      end
      default: ;
    endcase
  end

endmodule
